// File: rtl/fwd_arb_if.sv
// Bus bundle between the forwarder, the arbiter and the packetfilter cores.
//   slave  : arbiter view (forwarder requests and core responses in; grants and muxed data out)
//   master : forwarder/cores view (the opposite directions)
//   fwd_*           forwarder side: read address/strobe, done pulse, ready, muxed read data/length
//   rdy_for_fwd*    per-core packet-ready request and one-hot grant acknowledge
//   core_*          per-core broadcast address, read strobe, done pulse, packed read data/length
interface fwd_arb_if #(
  parameter int unsigned N      = 4,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LEN_W  = 32
);
  logic [ADDR_W-1:0]   fwd_addr;
  logic                fwd_rd_en;
  logic                fwd_done;
  logic                fwd_rdy;
  logic [DATA_W-1:0]   fwd_rd_data;
  logic                fwd_rd_data_vld;
  logic [LEN_W-1:0]    fwd_bytes;
  logic [N-1:0]        rdy_for_fwd;
  logic [N-1:0]        rdy_for_fwd_ack;
  logic [ADDR_W-1:0]   core_addr;
  logic [N-1:0]        core_rd_en;
  logic [N-1:0]        core_done;
  logic [N*DATA_W-1:0] core_rd_data;
  logic [N-1:0]        core_rd_data_vld;
  logic [N*LEN_W-1:0]  core_bytes;

  modport slave (
    input  fwd_addr, fwd_rd_en, fwd_done,
    input  rdy_for_fwd, core_rd_data, core_rd_data_vld, core_bytes,
    output fwd_rdy, fwd_rd_data, fwd_rd_data_vld, fwd_bytes,
    output rdy_for_fwd_ack, core_addr, core_rd_en, core_done
  );

  modport master (
    output fwd_addr, fwd_rd_en, fwd_done,
    output rdy_for_fwd, core_rd_data, core_rd_data_vld, core_bytes,
    input  fwd_rdy, fwd_rd_data, fwd_rd_data_vld, fwd_bytes,
    input  rdy_for_fwd_ack, core_addr, core_rd_en, core_done
  );
endinterface

// File: rtl/fwd_arb.sv
// Round-robin arbiter letting N packetfilter cores share one packet forwarder.
// A core raising rdy_for_fwd is granted (one-cycle ack), then owns the forwarder
// until fwd_done; read strobes, done and read data are routed to/from that core only.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : fwd_arb_if.slave bundle (forwarder side and per-core side)
module fwd_arb #(
  parameter int unsigned N                  = 4,
  parameter int unsigned PACKMEM_ADDR_WIDTH = 8,
  parameter int unsigned PACKMEM_DATA_WIDTH = 64,
  parameter int unsigned PLEN_WIDTH         = 32
) (
  input  logic    clk,
  input  logic    rst,
  fwd_arb_if.slave bus
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned DW = PACKMEM_DATA_WIDTH;
  localparam int unsigned LW = PLEN_WIDTH;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_n;
  logic [N-1:0]  sel, sel_n;
  logic [PW-1:0] ptr, ptr_n;
  logic [N-1:0]  ack, ack_n;
  logic          rdy_q;

  logic          found;
  logic [PW-1:0] pick;
  logic [N-1:0]  pick_oh;
  logic [PW-1:0] gnt_idx;

  // Round-robin search: first requester at or above ptr, else the lowest one (wrap).
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (!found && bus.rdy_for_fwd[i] && (PW'(i) >= ptr)) begin
        found = 1'b1;
        pick  = PW'(i);
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      if (!found && bus.rdy_for_fwd[i]) begin
        found = 1'b1;
        pick  = PW'(i);
      end
    end
  end

  // One-hot form of the chosen requester.
  always_comb begin
    pick_oh = '0;
    for (int i = 0; i < int'(N); i++) begin
      pick_oh[i] = (PW'(i) == pick);
    end
  end

  // Index of the currently granted core, used to advance ptr past it.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (sel[i]) gnt_idx = PW'(i);
    end
  end

  // State, grant and pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sel   <= '0;
      ptr   <= '0;
      ack   <= '0;
      rdy_q <= 1'b0;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      ptr   <= ptr_n;
      ack   <= ack_n;
      rdy_q <= (state_n == BUSY);
    end
  end

  // Next-state logic; requests are only sampled in IDLE, done only in BUSY.
  always_comb begin
    state_n = state;
    sel_n   = sel;
    ptr_n   = ptr;
    ack_n   = '0;
    unique case (state)
      IDLE: begin
        sel_n = '0;
        if (found) begin
          state_n = BUSY;
          sel_n   = pick_oh;
          ack_n   = pick_oh;
        end
      end
      BUSY: begin
        if (bus.fwd_done) begin
          state_n = IDLE;
          sel_n   = '0;
          ptr_n   = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        sel_n   = '0;
      end
    endcase
  end

  logic                          busy;
  logic [PACKMEM_ADDR_WIDTH-1:0] addr_c;
  logic [DW-1:0]                 rd_data_c;
  logic                          rd_vld_c;
  logic [LW-1:0]                 bytes_c;

  assign busy   = (state == BUSY);
  assign addr_c = bus.fwd_addr;

  // Return path: AND-OR mux over the one-hot grant, all zero when nobody is granted.
  always_comb begin
    rd_data_c = '0;
    rd_vld_c  = 1'b0;
    bytes_c   = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (sel[i]) begin
        rd_data_c = rd_data_c | bus.core_rd_data[i*DW +: DW];
        rd_vld_c  = rd_vld_c  | bus.core_rd_data_vld[i];
        bytes_c   = bytes_c   | bus.core_bytes[i*LW +: LW];
      end
    end
  end

  assign bus.fwd_rdy         = rdy_q;
  assign bus.rdy_for_fwd_ack = ack;
  assign bus.core_addr       = addr_c;
  assign bus.core_rd_en      = sel & {N{bus.fwd_rd_en & busy}};
  assign bus.core_done       = sel & {N{bus.fwd_done & busy}};
  assign bus.fwd_rd_data     = rd_data_c;
  assign bus.fwd_rd_data_vld = rd_vld_c;
  assign bus.fwd_bytes       = bytes_c;

endmodule

// File: tb/tb_fwd_arb.sv
// Bench for fwd_arb: directed scenarios with literal expectations, then random
// traffic, all outputs compared every cycle against a queue-free ownership model.
module tb_fwd_arb;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 64;
  localparam int LW = 32;

  logic clk;
  logic rst;

  fwd_arb_if #(.N(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

  fwd_arb #(
    .N(N), .PACKMEM_ADDR_WIDTH(AW), .PACKMEM_DATA_WIDTH(DW), .PLEN_WIDTH(LW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: which core owns the forwarder (-1 = none), the rotate pointer, the ack pulse.
  int           m_own = -1;
  int           m_ptr = 0;
  logic [N-1:0] m_ack = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_own = -1;
      m_ptr = 0;
      m_ack = '0;
    end else begin
      m_ack = '0;
      if (m_own >= 0) begin
        if (bus.fwd_done) begin
          m_ptr = (m_own + 1) % N;
          m_own = -1;
        end
      end else if (bus.rdy_for_fwd != '0) begin
        for (int k = 0; k < N; k++) begin
          if (m_own < 0 && bus.rdy_for_fwd[(m_ptr + k) % N]) begin
            m_own = (m_ptr + k) % N;
            m_ack[m_own] = 1'b1;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [N-1:0]  e_sel;
    logic [DW-1:0] e_data;
    logic          e_vld;
    logic [LW-1:0] e_bytes;
    e_sel   = '0;
    e_data  = '0;
    e_vld   = 1'b0;
    e_bytes = '0;
    if (m_own >= 0) begin
      e_sel[m_own] = 1'b1;
      e_data  = bus.core_rd_data[m_own*DW +: DW];
      e_vld   = bus.core_rd_data_vld[m_own];
      e_bytes = bus.core_bytes[m_own*LW +: LW];
    end
    chk("fwd_rdy",    64'(bus.fwd_rdy),         64'(m_own >= 0));
    chk("ack",        64'(bus.rdy_for_fwd_ack), 64'(m_ack));
    chk("core_addr",  64'(bus.core_addr),       64'(bus.fwd_addr));
    chk("core_rd_en", 64'(bus.core_rd_en),      64'(bus.fwd_rd_en ? e_sel : '0));
    chk("core_done",  64'(bus.core_done),       64'(bus.fwd_done ? e_sel : '0));
    chk("rd_data",    64'(bus.fwd_rd_data),     64'(e_data));
    chk("rd_vld",     64'(bus.fwd_rd_data_vld), 64'(e_vld));
    chk("bytes",      64'(bus.fwd_bytes),       64'(e_bytes));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fixed();
    for (int i = 0; i < N; i++) begin
      bus.core_rd_data[i*DW +: DW] = {32'hD00D_0000, 32'(i)};
      bus.core_bytes[i*LW +: LW]   = 32'd100 + 32'(i);
    end
    bus.core_rd_data_vld = 4'b0010;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("reset_fwd_rdy", 64'(bus.fwd_rdy), 64'd0);
    chk("reset_ack",     64'(bus.rdy_for_fwd_ack), 64'd0);
    tick();
    #2 rst = 1'b1;
    tick();
  endtask

  logic [N-1:0] order [5];

  initial begin
    rst = 1'b0;
    bus.fwd_addr    = '0;
    bus.fwd_rd_en   = 1'b0;
    bus.fwd_done    = 1'b0;
    bus.rdy_for_fwd = '0;
    set_fixed();
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;
    tick();
    do_reset();

    // Single requester: core 2.
    bus.rdy_for_fwd = 4'b0100;
    tick();
    chk("t39_ack",   64'(bus.rdy_for_fwd_ack), 64'h4);
    chk("t39_rdy",   64'(bus.fwd_rdy), 64'd1);
    chk("t39_bytes", 64'(bus.fwd_bytes), 64'd102);
    bus.rdy_for_fwd = '0;
    tick();
    chk("t39_ack_once", 64'(bus.rdy_for_fwd_ack), 64'd0);
    chk("t39_rdy_hold", 64'(bus.fwd_rdy), 64'd1);
    bus.fwd_done = 1'b1;
    tick();
    bus.fwd_done = 1'b0;
    chk("t39_release", 64'(bus.fwd_rdy), 64'd0);

    // All request: rotation 0,1,2,3,0 with ack two cycles after each done.
    do_reset();
    bus.rdy_for_fwd = 4'b1111;
    tick();
    chk("t40_grant0", 64'(bus.rdy_for_fwd_ack), 64'(order[0]));
    for (int k = 1; k < 5; k++) begin
      bus.fwd_done = 1'b1;
      tick();
      bus.fwd_done = 1'b0;
      chk("t40_gap", 64'(bus.rdy_for_fwd_ack), 64'd0);
      tick();
      chk("t40_grant", 64'(bus.rdy_for_fwd_ack), 64'(order[k]));
    end
    bus.fwd_done = 1'b1;
    tick();
    bus.fwd_done = 1'b0;
    bus.rdy_for_fwd = '0;
    tick();

    // Read path through core 1.
    do_reset();
    bus.rdy_for_fwd = 4'b0010;
    tick();
    bus.rdy_for_fwd = '0;
    bus.fwd_rd_en = 1'b1;
    bus.fwd_addr  = 8'h3C;
    #1;
    chk("t41_rd_en", 64'(bus.core_rd_en), 64'h2);
    chk("t41_addr",  64'(bus.core_addr), 64'h3C);
    chk("t41_data",  64'(bus.fwd_rd_data), 64'hD00D_0000_0000_0001);
    chk("t41_vld",   64'(bus.fwd_rd_data_vld), 64'd1);
    bus.fwd_rd_en = 1'b0;
    bus.fwd_done  = 1'b1;
    tick();
    bus.fwd_done = 1'b0;
    tick();

    // Core 3 drops its request mid-packet; grant held until done.
    do_reset();
    bus.rdy_for_fwd = 4'b1000;
    tick();
    chk("t42_ack", 64'(bus.rdy_for_fwd_ack), 64'h8);
    bus.rdy_for_fwd = '0;
    tick();
    tick();
    chk("t42_hold", 64'(bus.fwd_rdy), 64'd1);
    bus.fwd_done = 1'b1;
    #1;
    chk("t42_done", 64'(bus.core_done), 64'h8);
    tick();
    bus.fwd_done = 1'b0;
    #1;
    chk("t42_done_once", 64'(bus.core_done), 64'd0);
    chk("t42_idle", 64'(bus.fwd_rdy), 64'd0);

    // Strobes in IDLE are ignored.
    bus.fwd_done  = 1'b1;
    bus.fwd_rd_en = 1'b1;
    #1;
    chk("t43_done", 64'(bus.core_done), 64'd0);
    chk("t43_rd_en", 64'(bus.core_rd_en), 64'd0);
    tick();
    chk("t43_state", 64'(bus.fwd_rdy), 64'd0);
    bus.fwd_done  = 1'b0;
    bus.fwd_rd_en = 1'b0;
    bus.rdy_for_fwd = 4'b0010;
    tick();
    chk("t43_grant1", 64'(bus.rdy_for_fwd_ack), 64'h2);
    bus.rdy_for_fwd = '0;
    bus.fwd_done = 1'b1;
    tick();
    bus.fwd_done = 1'b0;
    tick();

    // Async reset mid-packet, pointer was 2; afterwards 1010 must pick core 1.
    bus.rdy_for_fwd = 4'b1000;
    tick();
    chk("t44_ack3", 64'(bus.rdy_for_fwd_ack), 64'h8);
    bus.rdy_for_fwd = '0;
    tick();
    bus.fwd_rd_en = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("t44_rdy_async", 64'(bus.fwd_rdy), 64'd0);
    chk("t44_rd_en_async", 64'(bus.core_rd_en), 64'd0);
    chk("t44_bytes_async", 64'(bus.fwd_bytes), 64'd0);
    bus.fwd_rd_en = 1'b0;
    bus.rdy_for_fwd = 4'b1010;
    tick();
    chk("t44_no_done", 64'(bus.core_done), 64'd0);
    #2 rst = 1'b1;
    tick();
    chk("t44_grant1", 64'(bus.rdy_for_fwd_ack), 64'h2);
    bus.rdy_for_fwd = '0;
    bus.fwd_done = 1'b1;
    tick();
    bus.fwd_done = 1'b0;
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bus.rdy_for_fwd      = N'($urandom);
      bus.fwd_rd_en        = 1'($urandom);
      bus.fwd_done         = ($urandom_range(0, 3) == 0);
      bus.fwd_addr         = AW'($urandom);
      bus.core_rd_data_vld = N'($urandom);
      for (int i = 0; i < N; i++) begin
        bus.core_rd_data[i*DW +: DW] = {$urandom, $urandom};
        bus.core_bytes[i*LW +: LW]   = $urandom;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwd_arb.md
FWD_ARB -- requirements
Module: fwd_arb

Parameters
REQ-001 SHALL have parameter N, default 4, giving the number of packetfilter cores sharing one forwarder.
REQ-002 SHALL have parameter PACKMEM_ADDR_WIDTH, default 8, giving the forwarder read-address width.
REQ-003 SHALL have parameter PACKMEM_DATA_WIDTH, default 64, giving the read-data width.
REQ-004 SHALL have parameter PLEN_WIDTH, default 32, giving the packet byte-length width.

Interface
REQ-005 SHALL have `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have `rst`, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have `fwd_addr`, input, PACKMEM_ADDR_WIDTH bits: the forwarder read address.
REQ-008 SHALL have `fwd_rd_en`, input, 1 bit: forwarder read strobe.
REQ-009 SHALL have `fwd_done`, input, 1 bit: forwarder finished the current packet (single-cycle pulse).
REQ-010 SHALL have `fwd_rdy`, output, 1 bit: a core is granted and a packet is available.
REQ-011 SHALL have `fwd_rd_data`, output, PACKMEM_DATA_WIDTH bits: read data from the granted core.
REQ-012 SHALL have `fwd_rd_data_vld`, output, 1 bit: read-data valid from the granted core.
REQ-013 SHALL have `fwd_bytes`, output, PLEN_WIDTH bits: accepted-packet length from the granted core.
REQ-014 SHALL have `rdy_for_fwd`, input, N bits: core i holds an accepted packet.
REQ-015 SHALL have `rdy_for_fwd_ack`, output, N bits: one-hot, single-cycle grant acknowledge.
REQ-016 SHALL have `core_addr`, output, PACKMEM_ADDR_WIDTH bits: fwd_addr broadcast to all cores.
REQ-017 SHALL have `core_rd_en`, output, N bits: per-core read strobe.
REQ-018 SHALL have `core_done`, output, N bits: per-core done pulse.
REQ-019 SHALL have `core_rd_data`, input, N*PACKMEM_DATA_WIDTH bits: core i occupies bits [i*W +: W].
REQ-020 SHALL have `core_rd_data_vld`, input, N bits: per-core read-data valid.
REQ-021 SHALL have `core_bytes`, input, N*PLEN_WIDTH bits: packed per-core packet lengths.

Function
REQ-022 SHALL implement states IDLE and BUSY, with registered one-hot `sel` (N bits) and round-robin pointer `ptr` (clog2(N) bits).
REQ-023 In IDLE with rdy_for_fwd != 0, SHALL grant at the next edge the first set bit at or after ptr, searching upward and wrapping from N-1 to 0.
REQ-024 On that grant edge SHALL load sel, enter BUSY, and pulse the chosen bit of rdy_for_fwd_ack high for exactly the first BUSY cycle.
REQ-025 In IDLE with rdy_for_fwd == 0, SHALL remain in IDLE with sel == 0.
REQ-026 fwd_rdy SHALL equal (state == BUSY), as a registered output.
REQ-027 core_addr SHALL equal fwd_addr combinationally, in every state.
REQ-028 core_rd_en SHALL equal sel AND {N{fwd_rd_en AND BUSY}}, combinationally.
REQ-029 fwd_rd_data, fwd_rd_data_vld and fwd_bytes SHALL be combinational muxes of the sel core's inputs; when sel == 0 they SHALL be 0.
REQ-030 In BUSY, fwd_done SHALL drive core_done = sel combinationally in that cycle.
REQ-031 At the edge ending the fwd_done cycle, SHALL clear sel, return to IDLE, and set ptr = (granted index + 1) mod N.
REQ-032 The minimum gap is one IDLE cycle: fwd_done in cycle t yields the next ack no earlier than cycle t+2.
REQ-033 In BUSY, SHALL ignore changes on rdy_for_fwd, including deassertion by the granted core; the grant is held until fwd_done.
REQ-034 SHALL ignore fwd_rd_en and fwd_done in IDLE: core_rd_en and core_done stay 0 and no state change occurs.
REQ-035 Simultaneous requests SHALL be resolved solely by ptr; a request arriving in the fwd_done cycle is evaluated in the following IDLE cycle.
REQ-036 No core SHALL be granted twice while another core requests continuously; the bound is N grants.

Reset
REQ-037 rst low SHALL immediately and asynchronously force state=IDLE, sel=0, ptr=0, fwd_rdy=0 and rdy_for_fwd_ack=0, with the combinational outputs following from sel=0.
REQ-038 Reset mid-packet SHALL abandon the grant with no core_done pulse, and arbitration SHALL restart from ptr=0 on the first edge with rst high.

Verification (N=4)
REQ-039 Reset, then rdy_for_fwd=4'b0100: ack=4'b0100 for 1 cycle, fwd_rdy=1, and fwd_bytes = core 2 length.
REQ-040 rdy_for_fwd=4'b1111 held, four packets each ended by fwd_done: grant order 0,1,2,3, then 0; each ack 2 cycles after the prior fwd_done.
REQ-041 With core 1 granted, fwd_rd_en=1 and fwd_addr=8'h3C: core_rd_en=4'b0010, core_addr=8'h3C, and fwd_rd_data = core 1 data.
REQ-042 Core 3 granted, then rdy_for_fwd[3] dropped before done: fwd_rdy stays 1 until fwd_done, then core_done=4'b1000 for 1 cycle.
REQ-043 fwd_done and fwd_rd_en pulsed in IDLE: core_done=0, core_rd_en=0, state unchanged.
REQ-044 rst asserted low mid-BUSY: fwd_rdy=0 and sel=0 without waiting for a clock edge; after release with rdy_for_fwd=4'b1010, core 1 is granted first.
